reverb_echo_engine: RTL



---
 rtl/reverb_pkg.sv | 19 +
 rtl/reverb_sat_mac.sv | 37 +++
 rtl/reverb_echo_engine.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/reverb_pkg.sv
// Shared types and constants for the echo engine: FSM states, sample width,
// Q15 unity gain and the saturation limits applied to every output sample.
package reverb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_X = 3'd1,
        RD_Y = 3'd2,
        CALC = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int          SAMPLE_W = 16;
    localparam logic [15:0] Q15_ONE  = 16'h7FFF;
    localparam int          SAT_MAX  = 32767;
    localparam int          SAT_MIN  = -32768;

endpackage

// File: rtl/reverb_sat_mac.sv
// Combinational feedback MAC: y = sat16(x + ((yd * gain) >>> 15)).
// gain is unsigned Q0.15, yd and x are signed 16-bit samples.
module reverb_sat_mac
    import reverb_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] x,
    input  logic signed [SAMPLE_W-1:0] yd,
    input  logic        [15:0]         gain,
    output logic signed [SAMPLE_W-1:0] y
);

    localparam logic signed [17:0] SUM_MAX = 18'(SAT_MAX);
    localparam logic signed [17:0] SUM_MIN = 18'(SAT_MIN);

    logic signed [31:0] prod;
    logic signed [31:0] scaled;
    logic signed [17:0] sum;
    logic               unused_scaled;

    // Upper bits of the scaled product are pure sign copies once narrowed to 18 bits.
    assign unused_scaled = ^scaled[31:18];

    // Multiply, rescale (arithmetic shift floors toward -inf), add and clamp.
    always_comb begin
        prod   = $signed({{16{yd[15]}}, yd}) * $signed({16'b0, gain});
        scaled = prod >>> 15;
        sum    = $signed({{2{x[15]}}, x}) + $signed(scaled[17:0]);
        if (sum > SUM_MAX) begin
            y = 16'(SAT_MAX);
        end else if (sum < SUM_MIN) begin
            y = 16'(SAT_MIN);
        end else begin
            y = sum[15:0];
        end
    end

endmodule

// File: rtl/reverb_echo_engine.sv
// Echo processor: for n in 0..N-1, y[n] = sat(x[n] + gain*y[n-K]) using a
// single synchronous-read memory port. Four cycles per sample:
// read x, read delayed y, compute, write y. done pulses once at the end.
module reverb_echo_engine
    import reverb_pkg::*;
#(
    parameter int                ADDR_W   = 18,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] IN_BASE  = 18'd0,
    parameter logic [ADDR_W-1:0] OUT_BASE = 18'd131072
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_len,
    input  logic [ADDR_W-1:0] delay,
    input  logic [15:0]       gain,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state_reg, state_next;

    logic [ADDR_W-1:0]          n_reg;
    logic [ADDR_W-1:0]          n_len_reg;
    logic [ADDR_W-1:0]          delay_reg;
    logic [15:0]                gain_reg;
    logic signed [SAMPLE_W-1:0] x_reg;
    logic signed [SAMPLE_W-1:0] y_reg;

    logic                       feedback;
    logic                       last_sample;
    logic signed [SAMPLE_W-1:0] yd;
    logic signed [SAMPLE_W-1:0] mac_y;
    logic                       unused_rdata;

    // Only the low half of each memory word carries a sample.
    assign unused_rdata = ^mem_rdata[DATA_W-1:SAMPLE_W];

    // A delayed read exists only once K samples have been produced; n and K are
    // stable from RD_Y through CALC, so the same term selects yd in CALC.
    assign feedback    = (delay_reg != '0) && (n_reg >= delay_reg);
    assign last_sample = (n_reg == n_len_reg - ADDR_W'(1));
    assign yd          = feedback ? $signed(mem_rdata[SAMPLE_W-1:0]) : '0;

    reverb_sat_mac u_mac (
        .x    (x_reg),
        .yd   (yd),
        .gain (gain_reg),
        .y    (mac_y)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Parameter latches, sample counter and x/y pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg     <= '0;
            n_len_reg <= '0;
            delay_reg <= '0;
            gain_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        n_reg     <= '0;
                        n_len_reg <= n_len;
                        delay_reg <= delay;
                        // Gain is Q0.15; bit 15 is outside the legal range and is dropped.
                        gain_reg  <= gain & Q15_ONE;
                    end
                end
                RD_Y: x_reg <= $signed(mem_rdata[SAMPLE_W-1:0]);
                CALC: y_reg <= mac_y;
                WR: begin
                    if (!last_sample) begin
                        n_reg <= n_reg + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and Moore-decoded memory port / status outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (n_len == '0) ? DONE : RD_X;
                end
            end
            RD_X: begin
                busy       = 1'b1;
                mem_addr   = IN_BASE + n_reg;
                state_next = RD_Y;
            end
            RD_Y: begin
                busy = 1'b1;
                if (feedback) begin
                    mem_addr = OUT_BASE + n_reg - delay_reg;
                end
                state_next = CALC;
            end
            CALC: begin
                busy       = 1'b1;
                state_next = WR;
            end
            WR: begin
                busy       = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = OUT_BASE + n_reg;
                mem_wdata  = {{(DATA_W-SAMPLE_W){y_reg[SAMPLE_W-1]}}, y_reg};
                state_next = last_sample ? DONE : RD_X;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
